// File: rtl/echo_pkg.sv
// Constants shared by the echo-cancellation datapath and its sample sink.
// Block parameters default to these values.
package echo_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int CLK_DIV      = 12500;
    localparam int SAMPLE_COUNT = 14970;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth and an occupancy counter.
// The head word is read combinationally from the read pointer.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full     = (count_q == (AW+1)'(DEPTH));
        empty    = (count_q == '0);
        do_pop   = pop && !empty;
        // A pop frees the slot the write lands in when full.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/audio_sample_sink.sv
// Captures echo-canceller output at the audio sample rate into a FIFO,
// tracking dropped samples and end of run.
module audio_sample_sink #(
    parameter int DATA_WIDTH   = echo_pkg::DATA_WIDTH,
    parameter int CLK_DIV      = echo_pkg::CLK_DIV,
    parameter int FIFO_DEPTH   = 16,
    parameter int SAMPLE_COUNT = echo_pkg::SAMPLE_COUNT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic [DATA_WIDTH-1:0]             sample_in,
    output logic                              sample_tick,
    output logic                              m_valid,
    output logic [DATA_WIDTH-1:0]             m_data,
    input  logic                              m_ready,
    output logic                              overflow,
    output logic                              done,
    output logic [$clog2(SAMPLE_COUNT+1)-1:0] sample_cnt
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(SAMPLE_COUNT + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    logic [DIV_W-1:0]      div_q, div_d;
    logic [CNT_W-1:0]      sample_cnt_q, sample_cnt_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;
    logic                  tick, pop, push;
    logic                  fifo_full, fifo_empty;
    logic [OCC_W-1:0]      fifo_count;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    always_comb begin
        tick = enable && !done_q && (div_q == DIV_W'(CLK_DIV - 1));
        pop  = !fifo_empty && m_ready;
        push = tick && (!fifo_full || pop);

        div_d = '0;
        if (enable && !done_q && !tick) begin
            div_d = div_q + DIV_W'(1);
        end

        sample_cnt_d = sample_cnt_q;
        overflow_d   = overflow_q;
        done_d       = done_q;
        // Dropped samples still count toward the run length.
        if (tick) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            if (!push) begin
                overflow_d = 1'b1;
            end
            if (sample_cnt_d == CNT_W'(SAMPLE_COUNT)) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q        <= '0;
            sample_cnt_q <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            div_q        <= div_d;
            sample_cnt_q <= sample_cnt_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (sample_in),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Memory is not reset, so the head is masked whenever nothing is queued.
    assign m_data      = (fifo_count != '0) ? fifo_rdata : '0;
    assign m_valid     = !fifo_empty;
    assign sample_tick = tick;
    assign overflow    = overflow_q;
    assign done        = done_q;
    assign sample_cnt  = sample_cnt_q;

endmodule

// File: tb/tb_audio_sample_sink.sv
// Directed checks for audio_sample_sink with CLK_DIV=4, FIFO_DEPTH=4,
// SAMPLE_COUNT=8.
module tb_audio_sample_sink;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] sample_in;
    logic        sample_tick;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready;
    logic        overflow;
    logic        done;
    logic [3:0]  sample_cnt;

    int errors = 0;
    int checks = 0;

    audio_sample_sink #(
        .DATA_WIDTH   (16),
        .CLK_DIV      (4),
        .FIFO_DEPTH   (4),
        .SAMPLE_COUNT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sample_in   (sample_in),
        .sample_tick (sample_tick),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .overflow    (overflow),
        .done        (done),
        .sample_cnt  (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves rst high one time unit after an edge; the next edge is
    // the first one counting if enable is raised now.
    task automatic do_reset();
        rst = 1'b0;
        enable = 1'b0;
        m_ready = 1'b0;
        sample_in = '0;
        cyc(1);
        rst = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tick"}, 32'(sample_tick), 0);
        chk({tag, "_valid"}, 32'(m_valid), 0);
        chk({tag, "_data"}, 32'(m_data), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_cnt"}, 32'(sample_cnt), 0);
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        m_ready = 1'b0;
        sample_in = '0;
        #2;
        chk_zero("reset");
        cyc(1);
        rst = 1'b1;

        // Basic cadence with an always-ready consumer
        enable = 1'b1;
        m_ready = 1'b1;
        sample_in = 16'h1234;
        cyc(2);
        chk("s1_no_tick_e2", 32'(sample_tick), 0);
        cyc(1);
        chk("s1_first_tick", 32'(sample_tick), 1);
        cyc(1);
        chk("s1_tick_low", 32'(sample_tick), 0);
        chk("s1_valid", 32'(m_valid), 1);
        chk("s1_data", 32'(m_data), 32'h1234);
        chk("s1_cnt", 32'(sample_cnt), 1);
        cyc(1);
        chk("s1_popped", 32'(m_valid), 0);
        cyc(2);
        chk("s1_second_tick", 32'(sample_tick), 1);
        cyc(1);
        chk("s1_valid2", 32'(m_valid), 1);
        chk("s1_data2", 32'(m_data), 32'h1234);
        chk("s1_cnt2", 32'(sample_cnt), 2);

        // Overflow with a stalled consumer
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            sample_in = 16'(k);
            cyc(4);
        end
        chk("s2_ovf", 32'(overflow), 1);
        chk("s2_cnt", 32'(sample_cnt), 5);
        chk("s2_valid", 32'(m_valid), 1);
        chk("s2_head_stable", 32'(m_data), 1);
        m_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            cyc(1);
            chk("s2_drain", 32'(m_data), 32'(k));
        end
        chk("s2_ovf_sticky", 32'(overflow), 1);

        // Full FIFO with a pop in the tick cycle
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample_in = 16'(16'h10 + k);
            cyc(4);
        end
        sample_in = 16'h14;
        cyc(3);
        chk("s3_tick", 32'(sample_tick), 1);
        chk("s3_full_head", 32'(m_data), 32'h10);
        m_ready = 1'b1;
        cyc(1);
        chk("s3_no_ovf", 32'(overflow), 0);
        chk("s3_cnt", 32'(sample_cnt), 5);
        chk("s3_head", 32'(m_data), 32'h11);
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("s3_drain", 32'(m_data), 32'(16'h12 + k));
        end

        // Run length reached
        do_reset();
        enable = 1'b1;
        m_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            sample_in = 16'(16'hA0 + k);
            cyc(4);
            chk("s4_data", 32'(m_data), 32'(16'hA0 + k));
            chk("s4_done", 32'(done), (k == 8) ? 1 : 0);
        end
        chk("s4_cnt", 32'(sample_cnt), 8);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("s4_no_tick", 32'(sample_tick), 0);
        end
        chk("s4_drained", 32'(m_valid), 0);
        chk("s4_done_sticky", 32'(done), 1);
        chk("s4_cnt_hold", 32'(sample_cnt), 8);
        #3;
        rst = 1'b0;
        #1;
        chk("s4_rst_done", 32'(done), 0);
        chk("s4_rst_cnt", 32'(sample_cnt), 0);

        // Asynchronous reset with three queued samples
        @(posedge clk);
        #1;
        rst = 1'b1;
        enable = 1'b1;
        m_ready = 1'b0;
        sample_in = 16'h55;
        cyc(4);
        sample_in = 16'h66;
        cyc(4);
        sample_in = 16'h77;
        cyc(4);
        chk("s5_valid_pre", 32'(m_valid), 1);
        chk("s5_cnt_pre", 32'(sample_cnt), 3);
        cyc(1);
        #3;
        rst = 1'b0;
        #1;
        chk_zero("s5_async");
        @(posedge clk);
        #1;
        rst = 1'b1;
        sample_in = 16'h99;
        cyc(2);
        chk("s5_no_stale", 32'(m_valid), 0);
        chk("s5_no_stale_d", 32'(m_data), 0);
        cyc(1);
        chk("s5_tick", 32'(sample_tick), 1);
        chk("s5_still_empty", 32'(m_valid), 0);
        cyc(1);
        chk("s5_new_data", 32'(m_data), 32'h99);
        m_ready = 1'b1;
        cyc(1);
        chk("s5_empty_after", 32'(m_valid), 0);

        // Enable dropped mid-count
        do_reset();
        enable = 1'b1;
        cyc(2);
        enable = 1'b0;
        #1;
        chk("s6_low_tick", 32'(sample_tick), 0);
        cyc(2);
        chk("s6_low_tick2", 32'(sample_tick), 0);
        enable = 1'b1;
        cyc(2);
        chk("s6_no_early", 32'(sample_tick), 0);
        cyc(1);
        chk("s6_tick", 32'(sample_tick), 1);
        chk("s6_cnt", 32'(sample_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
